demux12_4bit_stream_ctrl: RTL

Streaming controller that sequences a 1-to-2 4-bit demux. It accepts 4-bit words over a valid/ready input and steers each word to output A or B. Steering is either by an explicit select S or by alternating round-robin. Each output holds one registered word with its own valid/ready handshake, and each output counts delivered words.

---
 rtl/demux12_4bit_stream_ctrl_if.sv | 25 ++
 rtl/demux12_4bit_stream_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/demux12_4bit_stream_ctrl_if.sv
// rtl/demux12_4bit_stream_ctrl_if.sv - stream handshake bundle for the 1-to-2 demux controller
interface demux12_4bit_stream_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] x;
    logic             s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b;
    logic             b_valid;
    logic             b_ready;

    modport master (
        output x, s, in_valid, a_ready, b_ready,
        input  in_ready, a, a_valid, b, b_valid
    );

    modport slave (
        input  x, s, in_valid, a_ready, b_ready,
        output in_ready, a, a_valid, b, b_valid
    );
endinterface

// File: rtl/demux12_4bit_stream_ctrl.sv
// rtl/demux12_4bit_stream_ctrl.sv - steers input words to one of two single-slot output channels
module demux12_4bit_stream_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            mode_i,
    demux12_4bit_stream_ctrl_if.slave       bus_io,
    output logic                            turn_o,
    output logic [CNT_W-1:0]                cnt_a_o,
    output logic [CNT_W-1:0]                cnt_b_o
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_e;

    ch_state_e        a_st_q, b_st_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             turn_q, turn_d;

    logic tgt, a_free, b_free, in_ready, accept;
    logic load_a, load_b, drain_a, drain_b;

    // A channel can take a word if empty, or if its current word leaves on this same edge.
    always_comb begin
        tgt      = mode_i ? turn_q : bus_io.s;
        drain_a  = (a_st_q == ST_FULL) && bus_io.a_ready;
        drain_b  = (b_st_q == ST_FULL) && bus_io.b_ready;
        a_free   = (a_st_q == ST_EMPTY) || bus_io.a_ready;
        b_free   = (b_st_q == ST_EMPTY) || bus_io.b_ready;
        in_ready = tgt ? b_free : a_free;
        accept   = bus_io.in_valid && in_ready;
        load_a   = accept && !tgt;
        load_b   = accept && tgt;
        cnt_a_d  = drain_a ? cnt_a_q + CNT_W'(1) : cnt_a_q;
        cnt_b_d  = drain_b ? cnt_b_q + CNT_W'(1) : cnt_b_q;
        turn_d   = (accept && mode_i) ? ~turn_q : turn_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_st_q  <= ST_EMPTY;
            b_st_q  <= ST_EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            turn_q  <= 1'b0;
        end else begin
            case (a_st_q)
                ST_EMPTY: if (load_a) a_st_q <= ST_FULL;
                ST_FULL:  if (drain_a && !load_a) a_st_q <= ST_EMPTY;
                default:  a_st_q <= ST_EMPTY;
            endcase
            case (b_st_q)
                ST_EMPTY: if (load_b) b_st_q <= ST_FULL;
                ST_FULL:  if (drain_b && !load_b) b_st_q <= ST_EMPTY;
                default:  b_st_q <= ST_EMPTY;
            endcase
            if (load_a) a_q <= bus_io.x;
            if (load_b) b_q <= bus_io.x;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            turn_q  <= turn_d;
        end
    end

    assign bus_io.in_ready = in_ready;
    assign bus_io.a        = a_q;
    assign bus_io.b        = b_q;
    assign bus_io.a_valid  = (a_st_q == ST_FULL);
    assign bus_io.b_valid  = (b_st_q == ST_FULL);
    assign turn_o          = turn_q;
    assign cnt_a_o         = cnt_a_q;
    assign cnt_b_o         = cnt_b_q;
endmodule
